// File: rtl/axi4_lite_sim_pkg.sv
// Shared constants, channel state type and byte-lane helper for the AXI4-Lite simulation memory.
package axi4_lite_sim_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PROT_W = 3;

    localparam logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] PASS_ADDR    = 32'h2000_0000;
    localparam logic [DATA_W-1:0] PASS_MAGIC   = 32'd123456789;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RESP = 1'b1
    } ch_state_e;

    // Expands each strobe bit into a full byte of mask.
    function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi4_lite_sim_memory_if.sv
// AXI4-Lite bus (no bresp/rresp) between the picorv32 master and the simulation memory.
interface axi4_lite_sim_memory_if;
    import axi4_lite_sim_pkg::*;

    logic              mem_axi_awvalid;
    logic              mem_axi_awready;
    logic [ADDR_W-1:0] mem_axi_awaddr;
    logic [PROT_W-1:0] mem_axi_awprot;
    logic              mem_axi_wvalid;
    logic              mem_axi_wready;
    logic [DATA_W-1:0] mem_axi_wdata;
    logic [STRB_W-1:0] mem_axi_wstrb;
    logic              mem_axi_bvalid;
    logic              mem_axi_bready;
    logic              mem_axi_arvalid;
    logic              mem_axi_arready;
    logic [ADDR_W-1:0] mem_axi_araddr;
    logic [PROT_W-1:0] mem_axi_arprot;
    logic              mem_axi_rvalid;
    logic              mem_axi_rready;
    logic [DATA_W-1:0] mem_axi_rdata;

    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        input  mem_axi_bready,
        input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        input  mem_axi_rready,
        output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );

    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        output mem_axi_bready,
        output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        output mem_axi_rready,
        input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );

endinterface

// File: rtl/axi4_lite_sim_memory.sv
// Single-port AXI4-Lite slave RAM with console and pass-signature MMIO for simulation.
// `memory` is preloaded hierarchically by the wrapper and is untouched by reset.
module axi4_lite_sim_memory
    import axi4_lite_sim_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32768
) (
    input  logic                    clk,
    input  logic                    resetn,
    axi4_lite_sim_memory_if.slave   bus,
    output logic                    tests_passed
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * 4);

    logic [DATA_W-1:0] memory [MEM_WORDS];

    ch_state_e         rd_state_q, rd_state_d;
    ch_state_e         wr_state_q, wr_state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tests_passed_q, tests_passed_d;

    logic              ar_hs_c, aw_hs_c;
    logic              ar_in_range_c, aw_in_range_c;
    logic [IDX_W-1:0]  ar_idx_c, aw_idx_c;
    logic [DATA_W-1:0] wmask_c;
    logic              unused_prot_c;

    assign unused_prot_c = ^{bus.mem_axi_awprot, bus.mem_axi_arprot};

    // Ready signals are held low while in reset so nothing handshakes then.
    assign bus.mem_axi_arready = resetn && (rd_state_q == CH_IDLE);
    assign bus.mem_axi_awready = resetn && bus.mem_axi_awvalid && bus.mem_axi_wvalid
                                 && (wr_state_q == CH_IDLE);
    assign bus.mem_axi_wready  = bus.mem_axi_awready;
    assign bus.mem_axi_rvalid  = (rd_state_q == CH_RESP);
    assign bus.mem_axi_bvalid  = (wr_state_q == CH_RESP);
    assign bus.mem_axi_rdata   = rdata_q;
    assign tests_passed        = tests_passed_q;

    assign ar_hs_c       = bus.mem_axi_arvalid && bus.mem_axi_arready;
    assign aw_hs_c       = bus.mem_axi_awready;
    assign ar_in_range_c = (bus.mem_axi_araddr < MEM_BYTES);
    assign aw_in_range_c = (bus.mem_axi_awaddr < MEM_BYTES);
    assign ar_idx_c      = bus.mem_axi_araddr[IDX_W+1:2];
    assign aw_idx_c      = bus.mem_axi_awaddr[IDX_W+1:2];
    assign wmask_c       = strb_to_mask(bus.mem_axi_wstrb);

    // Read channel: capture data at the AR handshake, hold until R handshake.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            CH_IDLE: begin
                if (ar_hs_c) begin
                    rd_state_d = CH_RESP;
                    rdata_d    = ar_in_range_c ? memory[ar_idx_c] : '0;
                end
            end
            CH_RESP: begin
                if (bus.mem_axi_rready) begin
                    rd_state_d = CH_IDLE;
                end
            end
            default: rd_state_d = CH_IDLE;
        endcase
    end

    // Write channel: AW and W accepted together, response held until B handshake.
    always_comb begin
        wr_state_d     = wr_state_q;
        tests_passed_d = tests_passed_q;
        case (wr_state_q)
            CH_IDLE: begin
                if (aw_hs_c) begin
                    wr_state_d = CH_RESP;
                    if ((bus.mem_axi_awaddr == PASS_ADDR) && (bus.mem_axi_wdata == PASS_MAGIC)) begin
                        tests_passed_d = 1'b1;
                    end
                end
            end
            CH_RESP: begin
                if (bus.mem_axi_bready) begin
                    wr_state_d = CH_IDLE;
                end
            end
            default: wr_state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q     <= CH_IDLE;
            wr_state_q     <= CH_IDLE;
            rdata_q        <= '0;
            tests_passed_q <= 1'b0;
        end else begin
            rd_state_q     <= rd_state_d;
            wr_state_q     <= wr_state_d;
            rdata_q        <= rdata_d;
            tests_passed_q <= tests_passed_d;
        end
    end

    // Memory array has no reset so preloaded firmware survives a reset pulse.
    always_ff @(posedge clk) begin
        if (aw_hs_c && aw_in_range_c) begin
            memory[aw_idx_c] <= (memory[aw_idx_c] & ~wmask_c) | (bus.mem_axi_wdata & wmask_c);
        end
`ifndef SYNTHESIS
        if (aw_hs_c && (bus.mem_axi_awaddr == CONSOLE_ADDR)) begin
            $write("%c", bus.mem_axi_wdata[7:0]);
        end
`endif
    end

endmodule

// File: tb/tb_axi4_lite_sim_memory.sv
// Scoreboard bench for axi4_lite_sim_memory: drivers push expectations, a monitor pops on R/B handshakes.
module tb_axi4_lite_sim_memory;
    import axi4_lite_sim_pkg::*;

    localparam int unsigned MEM_WORDS = 32768;
    localparam logic [31:0] MEM_BYTES = 32'h0002_0000;

    logic clk = 1'b0;
    logic resetn;
    logic tests_passed;

    axi4_lite_sim_memory_if bus();

    axi4_lite_sim_memory #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus.slave),
        .tests_passed (tests_passed)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int rd_done = 0;
    int wr_done = 0;
    logic [31:0] exp_rd[$];
    logic        exp_wr[$];
    logic [31:0] model [int];
    logic        pass_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int w;
        w = int'(a[31:2]);
        if (a < MEM_BYTES && model.exists(w)) return model[w];
        return 32'h0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        logic [31:0] v;
        w = int'(a[31:2]);
        if (a < MEM_BYTES) begin
            v = model.exists(w) ? model[w] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            model[w] = v;
        end
        if (a == PASS_ADDR && d == PASS_MAGIC) pass_model = 1'b1;
    endfunction

    // Monitor: compare every completed response against the scoreboard.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus.mem_axi_rvalid && bus.mem_axi_rready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rdata", bus.mem_axi_rdata, exp_rd.pop_front());
                rd_done++;
            end
            if (bus.mem_axi_bvalid && bus.mem_axi_bready) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else check("tests_passed_at_b", 32'(tests_passed), 32'(exp_wr.pop_front()));
                wr_done++;
            end
        end
    end

    task automatic rd(input logic [31:0] a, input int hold);
        int start, n;
        logic [31:0] e;
        start = rd_done;
        @(posedge clk); #1;
        bus.mem_axi_arvalid = 1'b1;
        bus.mem_axi_araddr  = a;
        bus.mem_axi_rready  = (hold == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.mem_axi_arready && n < 20);
        if (!bus.mem_axi_arready) begin
            check("ar_timeout", 32'd0, 32'd1);
            bus.mem_axi_arvalid = 1'b0;
            return;
        end
        e = ref_read(a);
        exp_rd.push_back(e);
        @(posedge clk); #1;
        bus.mem_axi_arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_latency", 32'(bus.mem_axi_rvalid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            check("r_hold_rvalid", 32'(bus.mem_axi_rvalid), 32'd1);
            check("r_hold_rdata", bus.mem_axi_rdata, e);
            check("r_hold_arready", 32'(bus.mem_axi_arready), 32'd0);
            if (i < hold - 1) @(negedge clk);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.mem_axi_rready = 1'b1;
        end
        n = 0;
        while (rd_done == start && n < 50) begin @(negedge clk); n++; end
        if (rd_done == start) check("r_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.mem_axi_rready = 1'b0;
        @(negedge clk);
        check("rvalid_clear", 32'(bus.mem_axi_rvalid), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lead, input int bhold);
        int start, n;
        start = wr_done;
        @(posedge clk); #1;
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_awaddr  = a;
        bus.mem_axi_wvalid  = (lead == 0);
        bus.mem_axi_wdata   = d;
        bus.mem_axi_wstrb   = s;
        bus.mem_axi_bready  = (bhold == 0);
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            check("aw_without_w", 32'(bus.mem_axi_awready), 32'd0);
        end
        if (lead > 0) begin
            @(posedge clk); #1;
            bus.mem_axi_wvalid = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.mem_axi_awready && n < 20);
        if (!bus.mem_axi_awready) begin
            check("aw_timeout", 32'd0, 32'd1);
            bus.mem_axi_awvalid = 1'b0;
            bus.mem_axi_wvalid  = 1'b0;
            return;
        end
        check("wready_with_aw", 32'(bus.mem_axi_wready), 32'd1);
        ref_write(a, d, s);
        exp_wr.push_back(pass_model);
        @(posedge clk); #1;
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        @(negedge clk);
        check("bvalid_latency", 32'(bus.mem_axi_bvalid), 32'd1);
        if (bhold > 0) begin
            bus.mem_axi_awvalid = 1'b1;
            bus.mem_axi_wvalid  = 1'b1;
            bus.mem_axi_awaddr  = 32'h3000_0000;
            for (int i = 0; i < bhold; i++) begin
                check("b_hold_bvalid", 32'(bus.mem_axi_bvalid), 32'd1);
                check("b_hold_awready", 32'(bus.mem_axi_awready), 32'd0);
                if (i < bhold - 1) @(negedge clk);
            end
            @(posedge clk); #1;
            bus.mem_axi_awvalid = 1'b0;
            bus.mem_axi_wvalid  = 1'b0;
            bus.mem_axi_bready  = 1'b1;
        end
        n = 0;
        while (wr_done == start && n < 50) begin @(negedge clk); n++; end
        if (wr_done == start) check("b_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.mem_axi_bready = 1'b0;
        @(negedge clk);
        check("bvalid_clear", 32'(bus.mem_axi_bvalid), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            5:       return MEM_BYTES + 32'($urandom % 16);
            6:       return PASS_ADDR;
            7:       return 32'h4000_0000 | 32'($urandom);
            default: return 32'(($urandom % 64) * 4 + ($urandom % 4));
        endcase
    endfunction

    initial begin
        logic [31:0] v, old, a;
        int n, sr, sw;

        resetn              = 1'b0;
        pass_model          = 1'b0;
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_wvalid  = 1'b1;
        bus.mem_axi_awaddr  = 32'h0;
        bus.mem_axi_awprot  = 3'b0;
        bus.mem_axi_wdata   = 32'h0;
        bus.mem_axi_wstrb   = 4'hF;
        bus.mem_axi_bready  = 1'b0;
        bus.mem_axi_arvalid = 1'b1;
        bus.mem_axi_araddr  = 32'h0;
        bus.mem_axi_arprot  = 3'b0;
        bus.mem_axi_rready  = 1'b0;

        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            dut.memory[i] = v;
            model[i] = v;
        end
        dut.memory[4] = 32'hCAFE_BABE; model[4] = 32'hCAFE_BABE;
        dut.memory[8] = 32'h0;         model[8] = 32'h0;
        dut.memory[MEM_WORDS-1] = 32'h5555_AAAA; model[int'(MEM_WORDS-1)] = 32'h5555_AAAA;

        #12;
        check("rst_rvalid", 32'(bus.mem_axi_rvalid), 32'd0);
        check("rst_bvalid", 32'(bus.mem_axi_bvalid), 32'd0);
        check("rst_tests_passed", 32'(tests_passed), 32'd0);
        check("rst_rdata", bus.mem_axi_rdata, 32'h0);
        check("rst_arready", 32'(bus.mem_axi_arready), 32'd0);
        check("rst_awready", 32'(bus.mem_axi_awready), 32'd0);
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        bus.mem_axi_arvalid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("idle_arready", 32'(bus.mem_axi_arready), 32'd1);

        rd(32'h10, 0);
        wr(32'h20, 32'h1122_3344, 4'b0101, 0, 0);
        rd(32'h20, 0);
        check("strobe_model", ref_read(32'h20), 32'h0022_0044);
        rd(32'h13, 0);
        rd(MEM_BYTES - 4, 0);
        rd(MEM_BYTES, 0);

        wr(PASS_ADDR, 32'd5, 4'hF, 0, 0);
        check("pass_wrong_value", 32'(tests_passed), 32'd0);
        wr(PASS_ADDR, PASS_MAGIC, 4'hF, 0, 0);
        check("pass_magic", 32'(tests_passed), 32'd1);
        wr(PASS_ADDR, 32'd0, 4'hF, 0, 0);
        check("pass_sticky", 32'(tests_passed), 32'd1);

        rd(32'h10, 3);
        wr(32'h1C, 32'hDEAD_BEEF, 4'hF, 2, 3);
        rd(32'h1C, 0);
        wr(MEM_BYTES, 32'hFFFF_FFFF, 4'hF, 0, 0);
        rd(MEM_BYTES - 4, 1);

        wr(CONSOLE_ADDR, 32'h6F, 4'hF, 0, 0);
        wr(CONSOLE_ADDR, 32'h6B, 4'hF, 0, 0);
        wr(CONSOLE_ADDR, 32'h0A, 4'hF, 0, 0);

        // Same-cycle read and write to one word: read must see the old value.
        @(posedge clk); #1;
        old = ref_read(32'h14);
        sr = rd_done; sw = wr_done;
        bus.mem_axi_arvalid = 1'b1; bus.mem_axi_araddr = 32'h14; bus.mem_axi_rready = 1'b1;
        bus.mem_axi_awvalid = 1'b1; bus.mem_axi_awaddr = 32'h14; bus.mem_axi_wvalid = 1'b1;
        bus.mem_axi_wdata = 32'hA5A5_5A5A; bus.mem_axi_wstrb = 4'hF; bus.mem_axi_bready = 1'b1;
        @(negedge clk);
        check("both_arready", 32'(bus.mem_axi_arready), 32'd1);
        check("both_awready", 32'(bus.mem_axi_awready), 32'd1);
        exp_rd.push_back(old);
        ref_write(32'h14, 32'hA5A5_5A5A, 4'hF);
        exp_wr.push_back(pass_model);
        @(posedge clk); #1;
        bus.mem_axi_arvalid = 1'b0; bus.mem_axi_awvalid = 1'b0; bus.mem_axi_wvalid = 1'b0;
        n = 0;
        while ((rd_done == sr || wr_done == sw) && n < 50) begin @(negedge clk); n++; end
        if (rd_done == sr || wr_done == sw) check("same_cycle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.mem_axi_rready = 1'b0; bus.mem_axi_bready = 1'b0;
        rd(32'h14, 0);

        // Asynchronous reset with both responses pending and the pass flag set.
        @(posedge clk); #1;
        bus.mem_axi_arvalid = 1'b1; bus.mem_axi_araddr = 32'h10;
        bus.mem_axi_awvalid = 1'b1; bus.mem_axi_awaddr = 32'h24; bus.mem_axi_wvalid = 1'b1;
        bus.mem_axi_wdata = 32'h0BAD_F00D; bus.mem_axi_wstrb = 4'hF;
        @(negedge clk);
        check("pre_rst_ready", 32'(bus.mem_axi_arready && bus.mem_axi_awready), 32'd1);
        ref_write(32'h24, 32'h0BAD_F00D, 4'hF);
        @(posedge clk); #1;
        bus.mem_axi_arvalid = 1'b0; bus.mem_axi_awvalid = 1'b0; bus.mem_axi_wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 32'(bus.mem_axi_rvalid), 32'd1);
        check("pre_rst_bvalid", 32'(bus.mem_axi_bvalid), 32'd1);
        check("pre_rst_pass", 32'(tests_passed), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_rvalid", 32'(bus.mem_axi_rvalid), 32'd0);
        check("async_rst_bvalid", 32'(bus.mem_axi_bvalid), 32'd0);
        check("async_rst_pass", 32'(tests_passed), 32'd0);
        check("async_rst_rdata", bus.mem_axi_rdata, 32'h0);
        exp_rd.delete();
        exp_wr.delete();
        pass_model = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        rd(32'h10, 0);
        rd(32'h24, 0);
        rd(32'h20, 0);

        for (int k = 0; k < 150; k++) begin
            a = rand_addr();
            if ($urandom % 2 == 0) begin
                rd(a, int'($urandom % 3));
            end else begin
                v = ($urandom % 4 == 0) ? PASS_MAGIC : 32'($urandom);
                wr(a, v, 4'($urandom), int'($urandom % 3), int'($urandom % 3));
            end
        end

        repeat (4) @(negedge clk);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
